alu_operand_stage: RTL and testbench
====================================

// Module: alu_operand_stage
// PURPOSE
//  Registered, parametrised successor of the single-cycle ALU operand-A mux for the
//  pipelined Y86-64 core. Sits between decode and execute and selects both ALU operands,
//  alufun and set_cc from icode/ifun. Adds a valid/ready handshake, flush, and explicit
//  hold registers (no latch). Also flags illegal icodes and counts issued ALU operations.
// PARAMETERS
//  WIDTH       64  datapath width of valA/valB/valC/aluA/aluB
//  STACK_STEP  8   stack pointer adjust: call/push use -STEP, ret/pop use +STEP
//  CNT_W       32  width of the saturating ALU-op counter
// PORTS
//  clk         in   1      rising-edge clock
//  rst_n       in   1      asynchronous active-low reset
//  flush       in   1      synchronous squash of the stage (mispredict/exception)
//  in_valid    in   1      decode presents an instruction
//  in_ready    out  1      stage can accept this cycle
//  icode       in   4      Y86 instruction code
//  ifun        in   4      Y86 function code
//  valA        in   WIDTH  register operand A
//  valB        in   WIDTH  register operand B
//  valC        in   WIDTH  immediate / displacement
//  out_valid   out  1      registered operands valid for execute
//  out_ready   in   1      execute accepts this cycle
//  aluA        out  WIDTH  registered ALU operand A
//  aluB        out  WIDTH  registered ALU operand B
//  alufun      out  4      0=add 1=sub 2=and 3=xor
//  set_cc      out  1      execute must update condition codes
//  alu_en      out  1      instruction uses the ALU
//  ins_err     out  1      illegal icode (> 4'hB) in the output register
//  op_count    out  CNT_W  saturating count of accepted instructions with alu_en=1
// BEHAVIOUR
//  Reset (rst_n=0, async): out_valid=0, aluA=aluB=0, alufun=0, set_cc=0, alu_en=0,
//   ins_err=0, op_count=0. in_ready=1 in the first cycle after release.
//  Handshake: in_ready = !out_valid | out_ready (combinational). Accept = in_valid & in_ready.
//   On accept, all output registers load next edge; out_valid=1. If out_valid & out_ready
//   and no accept, out_valid clears. Latency: 1 cycle. Throughput: 1 per cycle.
//   Outputs must stay stable while out_valid & !out_ready.
//  Operand A: icode 2,6 -> valA; 3,4,5 -> valC; 8,A -> -STACK_STEP (two's complement, WIDTH bits);
//   9,B -> +STACK_STEP.
//  Operand B: icode 2,3 -> 0; 4,5,6,8,9,A,B -> valB.
//  alufun = ifun for icode 6; 0 (add) for every other ALU icode. set_cc = (icode==6).
//  alu_en = 1 for icode 2..6 and 8..B. For icode 0,1,7: alu_en=0, set_cc=0, alufun=0, and
//   aluA/aluB HOLD their previous values (explicit register hold, never a latch).
//  icode > 4'hB: same as the non-ALU case plus ins_err=1. ins_err clears on the next accept
//   of a legal icode.
//  ifun for icode 6 above 3 is passed through unchanged; execute handles it.
//  flush: next edge out_valid=0 and any same-cycle accept is discarded. aluA/aluB hold;
//   set_cc, alu_en and ins_err clear. op_count is not incremented by a discarded accept.
//  op_count increments by 1 on every non-flushed accept with alu_en=1 and saturates at
//   2^CNT_W-1 (no wrap).
//  Async reset mid-transfer drops the in-flight instruction immediately.
// TESTING
//  1. Reset, then accept icode=6 ifun=1 valA=5 valB=9 -> next cycle out_valid=1 aluA=5 aluB=9
//     alufun=1 set_cc=1 op_count=1.
//  2. Back-to-back accepts icode=3 (valC=0x10), then icode=A -> aluA=0x10 aluB=0, then
//     aluA=0xFFFF_FFFF_FFFF_FFF8 aluB=valB; 2 results in 2 cycles.
//  3. Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 and outputs stable;
//     release -> exactly one transfer per cycle, nothing lost or duplicated.
//  4. Accept icode=1 after icode=9 (+8) -> aluA/aluB unchanged, alu_en=0, op_count unchanged;
//     then icode=C -> ins_err=1.
//  5. flush with a same-cycle accept of icode=6 -> out_valid=0 next cycle, op_count unchanged.
//  6. CNT_W=2: 5 ALU accepts -> op_count saturates at 3. Assert rst_n=0 mid-stream -> all
//     outputs 0 without a clock edge.

Source files
------------

// File: rtl/alu_operand_stage.sv
// Registered ALU operand stage for the pipelined Y86-64 core: picks aluA/aluB, alufun and set_cc
// from icode/ifun behind a valid/ready handshake, with flush, illegal-icode flag and op counter.
module alu_operand_stage #(
    parameter int unsigned WIDTH      = 64,
    parameter int unsigned STACK_STEP = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       icode,
    input  logic [3:0]       ifun,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] valC,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluA,
    output logic [WIDTH-1:0] aluB,
    output logic [3:0]       alufun,
    output logic             set_cc,
    output logic             alu_en,
    output logic             ins_err,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [WIDTH-1:0] STEP_POS = WIDTH'(STACK_STEP);
    localparam logic [WIDTH-1:0] STEP_NEG = WIDTH'(0) - STEP_POS;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic             valid_q,   valid_d;
    logic [WIDTH-1:0] alu_a_q,   alu_a_d;
    logic [WIDTH-1:0] alu_b_q,   alu_b_d;
    logic [3:0]       alufun_q,  alufun_d;
    logic             set_cc_q,  set_cc_d;
    logic             alu_en_q,  alu_en_d;
    logic             ins_err_q, ins_err_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;

    logic             accept;
    logic [WIDTH-1:0] dec_a;
    logic [WIDTH-1:0] dec_b;
    logic [3:0]       dec_fun;
    logic             dec_cc;
    logic             dec_en;
    logic             dec_err;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Operand decode; non-ALU icodes keep the held operands instead of inferring a latch.
    always_comb begin
        dec_a   = alu_a_q;
        dec_b   = alu_b_q;
        dec_fun = 4'h0;
        dec_cc  = 1'b0;
        dec_en  = 1'b0;
        dec_err = 1'b0;
        case (icode)
            4'h2: begin dec_a = valA;     dec_b = '0;   dec_en = 1'b1; end
            4'h3: begin dec_a = valC;     dec_b = '0;   dec_en = 1'b1; end
            4'h4,
            4'h5: begin dec_a = valC;     dec_b = valB; dec_en = 1'b1; end
            4'h6: begin
                dec_a   = valA;
                dec_b   = valB;
                dec_fun = ifun;
                dec_cc  = 1'b1;
                dec_en  = 1'b1;
            end
            4'h8,
            4'hA: begin dec_a = STEP_NEG; dec_b = valB; dec_en = 1'b1; end
            4'h9,
            4'hB: begin dec_a = STEP_POS; dec_b = valB; dec_en = 1'b1; end
            default: dec_err = (icode > 4'hB);
        endcase
    end

    always_comb begin
        valid_d   = valid_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alufun_d  = alufun_q;
        set_cc_d  = set_cc_q;
        alu_en_d  = alu_en_q;
        ins_err_d = ins_err_q;
        cnt_d     = cnt_q;
        if (flush) begin
            valid_d   = 1'b0;
            set_cc_d  = 1'b0;
            alu_en_d  = 1'b0;
            ins_err_d = 1'b0;
        end else if (accept) begin
            valid_d   = 1'b1;
            alu_a_d   = dec_a;
            alu_b_d   = dec_b;
            alufun_d  = dec_fun;
            set_cc_d  = dec_cc;
            alu_en_d  = dec_en;
            ins_err_d = dec_err;
            if (dec_en && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alufun_q  <= 4'h0;
            set_cc_q  <= 1'b0;
            alu_en_q  <= 1'b0;
            ins_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alufun_q  <= alufun_d;
            set_cc_q  <= set_cc_d;
            alu_en_q  <= alu_en_d;
            ins_err_q <= ins_err_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_valid = valid_q;
    assign aluA      = alu_a_q;
    assign aluB      = alu_b_q;
    assign alufun    = alufun_q;
    assign set_cc    = set_cc_q;
    assign alu_en    = alu_en_q;
    assign ins_err   = ins_err_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Bench for alu_operand_stage: directed scenarios then random traffic against a cycle-level
// behavioural model; a second CNT_W=2 instance shares the stimulus to exercise saturation.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [3:0]  icode = 4'h0;
    logic [3:0]  ifun = 4'h0;
    logic [63:0] valA = '0;
    logic [63:0] valB = '0;
    logic [63:0] valC = '0;

    logic        in_ready, out_valid, set_cc, alu_en, ins_err;
    logic [63:0] aluA, aluB;
    logic [3:0]  alufun;
    logic [31:0] op_count;

    logic        in_ready2, out_valid2, set_cc2, alu_en2, ins_err2;
    logic [63:0] aluA2, aluB2;
    logic [3:0]  alufun2;
    logic [1:0]  op_count2;

    int n_vec = 0;
    int n_err = 0;

    // Model of the observable stage state
    logic        m_valid;
    logic [63:0] m_a, m_b;
    logic [3:0]  m_fun;
    logic        m_fun_known;
    logic        m_cc, m_en, m_err;
    int          m_cnt;

    alu_operand_stage #(.WIDTH(64), .STACK_STEP(8), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .out_valid(out_valid), .out_ready(out_ready), .aluA(aluA), .aluB(aluB),
        .alufun(alufun), .set_cc(set_cc), .alu_en(alu_en), .ins_err(ins_err),
        .op_count(op_count)
    );

    alu_operand_stage #(.WIDTH(64), .STACK_STEP(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
        .icode(icode), .ifun(ifun), .valA(valA), .valB(valB), .valC(valC),
        .out_valid(out_valid2), .out_ready(out_ready), .aluA(aluA2), .aluB(aluB2),
        .alufun(alufun2), .set_cc(set_cc2), .alu_en(alu_en2), .ins_err(ins_err2),
        .op_count(op_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_a = '0; m_b = '0; m_fun = 4'h0; m_fun_known = 1'b1;
        m_cc = 1'b0; m_en = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    // Apply one input vector for one clock, predicting the registered result from the rules.
    task automatic model_step();
        logic rdy, acc;
        rdy = !m_valid || out_ready;
        acc = in_valid && rdy;
        if (flush) begin
            m_valid = 1'b0; m_cc = 1'b0; m_en = 1'b0; m_err = 1'b0;
            m_fun_known = 1'b0;
        end else if (acc) begin
            m_valid = 1'b1;
            m_fun_known = 1'b1;
            if (icode inside {[4'h2:4'h6], [4'h8:4'hB]}) begin
                if (icode inside {4'h2, 4'h6})            m_a = valA;
                else if (icode inside {4'h3, 4'h4, 4'h5}) m_a = valC;
                else if (icode inside {4'h8, 4'hA})       m_a = 64'hFFFF_FFFF_FFFF_FFF8;
                else                                      m_a = 64'd8;
                m_b   = (icode inside {4'h2, 4'h3}) ? 64'd0 : valB;
                m_fun = (icode == 4'h6) ? ifun : 4'h0;
                m_cc  = (icode == 4'h6);
                m_en  = 1'b1;
                m_err = 1'b0;
                m_cnt++;
            end else begin
                m_fun = 4'h0; m_cc = 1'b0; m_en = 1'b0;
                m_err = (icode > 4'hB);
            end
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".aluA"},      aluA, m_a);
        chk({tag, ".aluB"},      aluB, m_b);
        if (m_fun_known) chk({tag, ".alufun"}, 64'(alufun), 64'(m_fun));
        chk({tag, ".set_cc"},    64'(set_cc), 64'(m_cc));
        chk({tag, ".alu_en"},    64'(alu_en), 64'(m_en));
        chk({tag, ".ins_err"},   64'(ins_err), 64'(m_err));
        chk({tag, ".op_count"},  64'(op_count), 64'(m_cnt));
        chk({tag, ".op_count_sat"}, 64'(op_count2), 64'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    // Drive a vector just after a rising edge, check in_ready, clock once, check outputs.
    task automatic cyc(input string tag, input logic iv, input logic fl, input logic ordy,
                       input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_valid = iv; flush = fl; out_ready = ordy;
        icode = ic; ifun = fn; valA = a; valB = b; valC = c;
        #1;
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(!m_valid || ordy));
        model_step();
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset.in_ready", 64'(in_ready), 64'd1);

        // 1: single OPq sub
        cyc("t1", 1, 0, 1, 4'h6, 4'h1, 64'd5, 64'd9, 64'd0);
        cyc("t1.drain", 0, 0, 1, 4'h0, 4'h0, '0, '0, '0);

        // 2: back-to-back irmovq then pushq
        cyc("t2.a", 1, 0, 1, 4'h3, 4'h0, 64'd1, 64'd2, 64'h10);
        cyc("t2.b", 1, 0, 1, 4'hA, 4'h0, 64'd3, 64'h1234, 64'h10);
        cyc("t2.drain", 0, 0, 1, 4'h0, 4'h0, '0, '0, '0);

        // 3: backpressure for three cycles, then release
        cyc("t3.load", 1, 0, 0, 4'h2, 4'h0, 64'hAA, 64'hBB, 64'hCC);
        for (int i = 0; i < 3; i++)
            cyc("t3.stall", 1, 0, 0, 4'h4, 4'h0, 64'h11 + 64'(i), 64'h22, 64'h33 + 64'(i));
        cyc("t3.rel1", 1, 0, 1, 4'h5, 4'h0, 64'h44, 64'h55, 64'h66);
        cyc("t3.rel2", 1, 0, 1, 4'h6, 4'h3, 64'h77, 64'h88, 64'h99);
        cyc("t3.drain", 0, 0, 1, 4'h0, 4'h0, '0, '0, '0);

        // 4: popq then nop holds operands; then illegal icode
        cyc("t4.pop", 1, 0, 1, 4'h9, 4'h0, 64'h1, 64'h500, 64'h2);
        cyc("t4.nop", 1, 0, 1, 4'h1, 4'h0, 64'hDEAD, 64'hBEEF, 64'hF00D);
        cyc("t4.bad", 1, 0, 1, 4'hC, 4'h0, 64'hDEAD, 64'hBEEF, 64'hF00D);
        cyc("t4.legal", 1, 0, 1, 4'h2, 4'h0, 64'h7, 64'h8, 64'h9);

        // 5: flush discards a same-cycle accept
        cyc("t5.flush", 1, 1, 1, 4'h6, 4'h2, 64'h3, 64'h4, 64'h5);
        cyc("t5.idle", 0, 0, 1, 4'h0, 4'h0, '0, '0, '0);

        // 6: saturation on the narrow counter
        for (int i = 0; i < 5; i++)
            cyc("t6.sat", 1, 0, 1, 4'h8, 4'h0, 64'(i), 64'h100 + 64'(i), 64'(i));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", ($urandom_range(9) < 7), ($urandom_range(19) == 0), ($urandom_range(9) < 7),
                4'($urandom_range(15)), 4'($urandom_range(15)),
                {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
        end

        // Async reset mid-stream, no clock edge in between
        cyc("ar.load", 1, 0, 0, 4'h6, 4'h0, 64'h5A5A, 64'hA5A5, 64'h0);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        chk("async_rst.out_valid2", 64'(out_valid2), 64'd0);
        chk("async_rst.aluA2", aluA2, 64'd0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
